// File: rtl/uart_tx_buffered_pkg.sv
// Shared definitions for the buffered UART transmitter: serializer state
// encodings, frame lengths and the UART MMIO map used by the IO decode.
// UART_TX_PARITY_EN selects the 11-bit (even parity) frame.
package uart_tx_buffered_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif

    // UART MMIO map shared with the CPU IO decode.
    localparam logic [31:0] UART_STATUS_ADDR = 32'h8000_0000;
    localparam logic [31:0] UART_RX_ADDR     = 32'h8000_0004;
    localparam logic [31:0] UART_TX_ADDR     = 32'h8000_0008;

    // Even parity bit: makes the total count of ones (data + parity) even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte handshake from the MMIO store decode into the UART TX buffer.
interface uart_tx_buffered_if;

    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready
    );

    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready
    );

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock circular FIFO. Pointers wrap naturally because DEPTH is a
// power of two; the head entry is read straight from storage.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == LVL_W'(DEPTH));
    assign empty     = (count == '0);
    assign level     = count;
    assign head_data = mem[rd_ptr];
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;

    // Storage write on accepted push.
    // NOTE: the data array is deliberately not reset; an entry is only ever
    // read after it has been written, and leaving it out keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push and pop keep count.
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO feeding an 8N1 serializer.
// Define UART_TX_PARITY_EN for an 8E1 frame (PARITY state after DATA).
module uart_tx_buffered
    import uart_tx_buffered_pkg::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    uart_tx_buffered_if.slave           in_if,
    output logic                        serial_out,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] tx_level
);

    localparam int CYCLES_PER_BAUD = CLOCK_FREQ / BAUD_RATE;
    localparam int BAUD_W          = $clog2(CYCLES_PER_BAUD);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CYCLES_PER_BAUD - 1);

    tx_state_e         state, state_next;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        tx_byte, tx_byte_next;
    logic              serial_next;
    logic              baud_tick;

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [7:0]        fifo_head;

    // Ready depends only on fullness, never on a same-cycle pop.
    assign in_if.data_in_ready = !fifo_full;
    assign baud_tick           = (baud_cnt == BAUD_LAST);
    assign tx_busy             = (state != ST_IDLE) || (tx_level != '0);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (in_if.data_in_valid && in_if.data_in_ready),
        .push_data (in_if.data_in),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (tx_level)
    );

    // Serializer registers, including the registered TX line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            tx_byte    <= '0;
            serial_out <= 1'b1;
        end else begin
            state      <= state_next;
            baud_cnt   <= baud_cnt_next;
            bit_idx    <= bit_idx_next;
            tx_byte    <= tx_byte_next;
            serial_out <= serial_next;
        end
    end

    // Next-state, next line level and FIFO pop for the serializer.
    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_next    = state;
        baud_cnt_next = '0;
        bit_idx_next  = bit_idx;
        tx_byte_next  = tx_byte;
        serial_next   = serial_out;
        fifo_pop      = 1'b0;

        if (state != ST_IDLE && !baud_tick) begin
            baud_cnt_next = baud_cnt + 1'b1;
        end

        case (state)
            ST_IDLE: begin
                serial_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    tx_byte_next = fifo_head;
                    state_next   = ST_START;
                    serial_next  = 1'b0;
                end
            end
            ST_START: begin
                if (baud_tick) begin
                    state_next   = ST_DATA;
                    bit_idx_next = '0;
                    serial_next  = tx_byte[0];
                end
            end
            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_next  = ST_PARITY;
                        serial_next = even_parity(tx_byte);
`else
                        state_next  = ST_STOP;
                        serial_next = 1'b1;
`endif
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                        serial_next  = tx_byte[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick) begin
                    state_next  = ST_STOP;
                    serial_next = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick) begin
                    if (!fifo_empty) begin
                        // Chain straight into the next start bit.
                        fifo_pop     = 1'b1;
                        tx_byte_next = fifo_head;
                        state_next   = ST_START;
                        serial_next  = 1'b0;
                    end else begin
                        state_next  = ST_IDLE;
                        serial_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next  = ST_IDLE;
                serial_next = 1'b1;
            end
        endcase
    end

endmodule
